// File: rtl/ps2_host_tx.sv
// PS/2 host-to-device transmitter: inhibits the bus, drives a start bit, shifts one command
// byte out on device-generated clock edges and checks the device ACK.
module ps2_host_tx #(
    parameter int unsigned INHIBIT_CYCLES = 5000,
    parameter int unsigned SETUP_CYCLES   = 100,
    parameter int unsigned START_TIMEOUT  = 750000,
    parameter int unsigned BIT_TIMEOUT    = 100000
) (
    input  logic       clk,
    input  logic       resetn,
    input  logic [7:0] cmd_data,
    input  logic       cmd_send,
    input  logic       ps2_clk_in,
    input  logic       ps2_dat_in,
    output logic       ps2_clk_oe,
    output logic       ps2_dat_oe,
    output logic       busy,
    output logic       cmd_sent,
    output logic       cmd_error
);
    localparam int unsigned CNT_MAX = (INHIBIT_CYCLES > SETUP_CYCLES) ? INHIBIT_CYCLES
                                                                      : SETUP_CYCLES;
    localparam int unsigned TMO_MAX = (START_TIMEOUT > BIT_TIMEOUT) ? START_TIMEOUT
                                                                    : BIT_TIMEOUT;
    localparam int unsigned CW = $clog2(CNT_MAX + 1);
    localparam int unsigned TW = $clog2(TMO_MAX + 1);

    typedef enum logic [2:0] {
        StIdle,
        StInhibit,
        StReq,
        StShift,
        StWaitIdle,
        StFail
    } state_t;

    state_t        state;
    logic [CW-1:0] cnt;
    logic [TW-1:0] tmo;
    logic [3:0]    edge_cnt;
    logic [9:0]    tx_sr;

    logic clk_s1, clk_s2, clk_prev;
    logic dat_s1, dat_s2;
    logic fe;

    // Synchronizers reset high so a released bus never looks like a falling edge.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            clk_s1   <= 1'b1;
            clk_s2   <= 1'b1;
            clk_prev <= 1'b1;
            dat_s1   <= 1'b1;
            dat_s2   <= 1'b1;
        end else begin
            clk_s1   <= ps2_clk_in;
            clk_s2   <= clk_s1;
            clk_prev <= clk_s2;
            dat_s1   <= ps2_dat_in;
            dat_s2   <= dat_s1;
        end
    end

    assign fe = clk_prev & ~clk_s2;

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state      <= StIdle;
            cnt        <= '0;
            tmo        <= '0;
            edge_cnt   <= '0;
            tx_sr      <= '0;
            ps2_clk_oe <= 1'b0;
            ps2_dat_oe <= 1'b0;
            busy       <= 1'b0;
            cmd_sent   <= 1'b0;
            cmd_error  <= 1'b0;
        end else begin
            cmd_sent  <= 1'b0;
            cmd_error <= 1'b0;
            unique case (state)
                // The error cycle is already not busy, so it accepts commands like idle.
                StIdle, StFail: begin
                    ps2_clk_oe <= 1'b0;
                    ps2_dat_oe <= 1'b0;
                    state      <= StIdle;
                    if (cmd_send) begin
                        tx_sr      <= {1'b1, ~^cmd_data, cmd_data};
                        cnt        <= CW'(INHIBIT_CYCLES - 1);
                        ps2_clk_oe <= 1'b1;
                        busy       <= 1'b1;
                        state      <= StInhibit;
                    end
                end
                StInhibit: begin
                    if (cnt == '0) begin
                        cnt        <= CW'(SETUP_CYCLES - 1);
                        ps2_dat_oe <= 1'b1;
                        state      <= StReq;
                    end else begin
                        cnt <= cnt - 1'b1;
                    end
                end
                StReq: begin
                    if (cnt == '0) begin
                        ps2_clk_oe <= 1'b0;
                        edge_cnt   <= '0;
                        tmo        <= TW'(START_TIMEOUT);
                        state      <= StShift;
                    end else begin
                        cnt <= cnt - 1'b1;
                    end
                end
                StShift: begin
                    if (fe) begin
                        edge_cnt <= edge_cnt + 4'd1;
                        tmo      <= TW'(BIT_TIMEOUT);
                        if (edge_cnt == 4'd10) begin
                            if (!dat_s2) begin
                                state <= StWaitIdle;
                            end else begin
                                ps2_dat_oe <= 1'b0;
                                busy       <= 1'b0;
                                cmd_error  <= 1'b1;
                                state      <= StFail;
                            end
                        end else begin
                            ps2_dat_oe <= ~tx_sr[0];
                            tx_sr      <= {1'b0, tx_sr[9:1]};
                        end
                    end else if (tmo <= TW'(1)) begin
                        ps2_dat_oe <= 1'b0;
                        busy       <= 1'b0;
                        cmd_error  <= 1'b1;
                        state      <= StFail;
                    end else begin
                        tmo <= tmo - 1'b1;
                    end
                end
                StWaitIdle: begin
                    ps2_clk_oe <= 1'b0;
                    ps2_dat_oe <= 1'b0;
                    if (clk_s2 && dat_s2) begin
                        busy     <= 1'b0;
                        cmd_sent <= 1'b1;
                        state    <= StIdle;
                    end else if (fe) begin
                        tmo <= TW'(BIT_TIMEOUT);
                    end else if (tmo <= TW'(1)) begin
                        busy      <= 1'b0;
                        cmd_error <= 1'b1;
                        state     <= StFail;
                    end else begin
                        tmo <= tmo - 1'b1;
                    end
                end
                default: begin
                    ps2_clk_oe <= 1'b0;
                    ps2_dat_oe <= 1'b0;
                    busy       <= 1'b0;
                    state      <= StIdle;
                end
            endcase
        end
    end

endmodule
